uart_rx_deframer: RTL and testbench

Receive-side counterpart of the UART Tx path. It oversamples the asynchronous serial line on UCLK, detects and validates the start bit, and shifts in DATA_WIDTH bits LSB first. It then checks the optional parity bit and the stop bit, and presents the assembled word with a one-cycle valid strobe and error flags to the APB-side receive logic.

---
 rtl/uart_rx_deframer.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises and oversamples the serial line, checks parity and stop bit.
// Optional macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 majority sampling around each sample point.
module uart_rx_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  rx_serial_in,
    input  logic                  parity_enable,
    input  logic                  parity_odd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] MID_S = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID_F = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
    } state_t;

    state_t                state_q;
    logic                  rx_meta_q, rx_sync_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pen_q, podd_q, pmis_q;
    logic                  valid_q, perr_q, ferr_q, busy_q;
    logic [CW-1:0]         mid_d;
    logic                  at_pt_d;
    logic                  sample_d;

    assign mid_d   = (state_q == START) ? MID_S : MID_F;
    assign at_pt_d = (cnt_q == mid_d);

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial_in;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q;

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            vote_q <= 2'b11;
        end else begin
            if (cnt_q == mid_d - CW'(2)) vote_q[0] <= rx_sync_q;
            if (cnt_q == mid_d - CW'(1)) vote_q[1] <= rx_sync_q;
        end
    end

    assign sample_d = (vote_q[0] & vote_q[1]) |
                      (vote_q[0] & rx_sync_q) |
                      (vote_q[1] & rx_sync_q);
`else
    assign sample_d = rx_sync_q;
`endif

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            pmis_q  <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        pen_q   <= parity_enable;
                        podd_q  <= parity_odd;
                        pmis_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (at_pt_d) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (!sample_d) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (at_pt_d) begin
                        shift_q <= {sample_d, shift_q[DATA_WIDTH-1:1]};
                        cnt_q   <= '0;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LAST)
                            state_q <= pen_q ? PARITY : STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_pt_d) begin
                        pmis_q  <= sample_d ^ (^shift_q) ^ podd_q;
                        cnt_q   <= '0;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (at_pt_d) begin
                        data_q  <= shift_q;
                        perr_q  <= pmis_q;
                        ferr_q  <= ~sample_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= ~sample_d;
                        state_q <= sample_d ? IDLE : BREAK_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    // A held-low line must not restart a frame until it recovers.
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: table of frames plus hand-written corner sequences.
// Expected words are queued when a frame is driven and compared when data_valid strobes.
module tb_uart_rx_deframer;

    localparam int W  = 8;
    localparam int OS = 16;

    logic         UCLK = 1'b0;
    logic         reset = 1'b0;
    logic         rx = 1'b1;
    logic         pen = 1'b0;
    logic         podd = 1'b0;
    logic [W-1:0] dout;
    logic         dv, perr, ferr, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int strobes = 0;
    int s0;
    logic lat_chk = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       pe, po, flip, stop;
        logic [7:0] xd;
        logic       xp, xf;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[8];

    uart_rx_deframer #(.DATA_WIDTH(W), .OVERSAMPLE(OS)) dut (
        .UCLK          (UCLK),
        .reset         (reset),
        .rx_serial_in  (rx),
        .parity_enable (pen),
        .parity_odd    (podd),
        .data_out      (dout),
        .data_valid    (dv),
        .parity_error  (perr),
        .framing_error (ferr),
        .busy          (busy)
    );

    always #5 UCLK = ~UCLK;

    always @(posedge UCLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge UCLK) begin
        if (reset && dv === 1'b1) begin
            strobes++;
            if (lat_chk) begin
                chk("latency", cyc - t0, 154);
                lat_chk = 1'b0;
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got data %0h expected none", dout);
            end else begin
                mon_e = sb.pop_front();
                chk("data", dout, mon_e.d);
                chk("parity_error", perr, mon_e.p);
                chk("framing_error", ferr, mon_e.f);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic po,
                        input logic flip, input logic stop, input int spike,
                        input int abort, input logic bchk);
        logic [11:0] bits;
        int nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe) begin
            bits[9]  = (^d) ^ po ^ flip;
            bits[10] = stop;
            nb = 11;
        end else begin
            bits[9] = stop;
            nb = 10;
        end
        pen  = pe;
        podd = po;
        for (int e = 0; e < nb * OS; e++) begin
            @(negedge UCLK);
            if (e == 0) t0 = cyc + 1;
            if (bchk && e == 2)   chk("busy_before_start", busy, 0);
            if (bchk && e == 3)   chk("busy_at_start", busy, 1);
            if (bchk && e == 154) chk("busy_before_stop", busy, 1);
            if (bchk && e == 155) chk("busy_after_stop", busy, 0);
            if (e == 40) begin
                pen  = ~pen;
                podd = ~podd;
            end
            if (e == abort) begin
                reset = 1'b0;
                return;
            end
            rx = (e == spike) ? ~bits[e/OS] : bits[e/OS];
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb.size() > 0; i++) @(negedge UCLK);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL missing_strobe got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[3] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};

        repeat (3) @(negedge UCLK);
        chk("rst_data", dout, 0);
        chk("rst_valid", dv, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (4) @(negedge UCLK);

        for (int i = 0; i < 8; i++) begin
            sb.push_back('{tbl[i].xd, tbl[i].xp, tbl[i].xf});
            lat_chk = (i == 0);
            send(tbl[i].d, tbl[i].pe, tbl[i].po, tbl[i].flip, tbl[i].stop,
                 -1, -1, i == 0);
            @(negedge UCLK);
            rx = 1'b1;
            drain();
            repeat (20) @(negedge UCLK);
        end

        s0 = strobes;
        rx = 1'b0;
        repeat (4) @(negedge UCLK);
        rx = 1'b1;
        repeat (30) @(negedge UCLK);
        chk("glitch_strobes", strobes, s0);
        chk("glitch_data", dout, 8'h96);
        chk("glitch_perr", perr, 0);
        chk("glitch_ferr", ferr, 1);
        chk("glitch_busy", busy, 0);

        s0 = strobes;
        sb.push_back('{8'h81, 1'b0, 1'b1});
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        repeat (640) @(negedge UCLK);
        chk("break_strobes", strobes, s0 + 1);
        chk("break_busy", busy, 1);
        rx = 1'b1;
        repeat (5) @(negedge UCLK);
        chk("break_busy_end", busy, 0);
        chk("break_ferr_hold", ferr, 1);
        drain();

        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 70, 1'b0);
        #1;
        chk("abort_data", dout, 0);
        chk("abort_valid", dv, 0);
        chk("abort_ferr", ferr, 0);
        chk("abort_perr", perr, 0);
        chk("abort_busy", busy, 0);
        rx = 1'b1;
        repeat (3) @(negedge UCLK);
        reset = 1'b1;
        repeat (4) @(negedge UCLK);
        sb.push_back('{8'h55, 1'b0, 1'b0});
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        drain();
        repeat (10) @(negedge UCLK);

        sb.push_back('{8'h12, 1'b0, 1'b0});
        sb.push_back('{8'hE7, 1'b1, 1'b0});
        send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        send(8'hE7, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        drain();
        repeat (10) @(negedge UCLK);

`ifdef UART_RX_MAJORITY_VOTE_EN
        sb.push_back('{8'h00, 1'b0, 1'b0});
`else
        sb.push_back('{8'h04, 1'b0, 1'b0});
`endif
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 56, -1, 1'b0);
        drain();
        repeat (10) @(negedge UCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
